// File: rtl/clock_monitor_if.sv
// rtl/clock_monitor_if.sv - monitored-clock input and measurement outputs of clock_monitor.
// i_stop exists only when CLOCK_MONITOR_STOP_EN is defined.
interface clock_monitor_if #(
   parameter int p_width = 16
);
   logic               i_in;
`ifdef CLOCK_MONITOR_STOP_EN
   logic               i_stop;
`endif
   logic               o_posedge;
   logic               o_negedge;
   logic               o_edge;
   logic [p_width-1:0] o_period;
   logic               o_locked;
   logic               o_lost;

   modport master (
`ifdef CLOCK_MONITOR_STOP_EN
      output i_stop,
`endif
      output i_in,
      input  o_posedge,
      input  o_negedge,
      input  o_edge,
      input  o_period,
      input  o_locked,
      input  o_lost
   );

   modport slave (
`ifdef CLOCK_MONITOR_STOP_EN
      input  i_stop,
`endif
      input  i_in,
      output o_posedge,
      output o_negedge,
      output o_edge,
      output o_period,
      output o_locked,
      output o_lost
   );
endinterface

// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - synchronises a slow clock, measures its half-period and tracks lock.
// Optional CLOCK_MONITOR_STOP_EN adds i_stop, which freezes the counter and lock state.
module clock_monitor #(
   parameter int p_divider    = 50,
   parameter int p_tolerance  = 2,
   parameter int p_lock_count = 4,
   parameter int p_width      = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   clock_monitor_if.slave  mon
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam int c_good_w = $clog2(p_lock_count + 1);
   localparam logic [p_width-1:0] c_lo =
      (p_divider > p_tolerance) ? p_width'(p_divider - p_tolerance) : '0;
   localparam logic [p_width-1:0] c_hi      = p_width'(p_divider + p_tolerance);
   localparam logic [p_width-1:0] c_timeout = p_width'(p_divider + p_tolerance + 1);
   localparam logic [c_good_w-1:0] c_lock   = c_good_w'(p_lock_count);

   logic                r_s1, r_s2, r_s3;
   logic                r_pos, r_neg;
   logic [p_width-1:0]  r_cnt;
   logic [p_width-1:0]  r_period;
   logic [c_good_w-1:0] r_good;
   logic                r_lost;
   state_t              r_state;

   state_t              w_state_next;
   logic [c_good_w-1:0] w_good_next;
   logic                w_lost_next;
   logic                w_edge;
   logic                w_fsm_edge;
   logic                w_in_range;
   logic                w_timeout;
   logic                w_stop;
   logic                w_skip;

`ifdef CLOCK_MONITOR_STOP_EN
   // After a stop the running count is stale, so the first edge only re-arms measurement.
   logic r_skip;

   assign w_stop = mon.i_stop;
   assign w_skip = r_skip;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_skip <= 1'b0;
      end else if (w_stop) begin
         r_skip <= 1'b1;
      end else if (w_edge) begin
         r_skip <= 1'b0;
      end
   end
`else
   assign w_stop = 1'b0;
   assign w_skip = 1'b0;
`endif

   assign w_edge     = r_pos | r_neg;
   assign w_fsm_edge = w_edge && !w_stop && !w_skip;
   assign w_in_range = (r_cnt >= c_lo) && (r_cnt <= c_hi);
   assign w_timeout  = !w_edge && !w_stop && !w_skip && (r_cnt == c_timeout);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_s3     <= 1'b0;
         r_pos    <= 1'b0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_period <= '0;
      end else begin
         r_s1  <= mon.i_in;
         r_s2  <= r_s1;
         r_s3  <= r_s2;
         r_pos <= r_s2 & ~r_s3;
         r_neg <= ~r_s2 & r_s3;
         if (w_edge) begin
            r_period <= r_cnt;
         end
         if (w_stop) begin
            r_cnt <= r_cnt;
         end else if (w_edge) begin
            r_cnt <= p_width'(1);
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_good  <= '0;
         r_lost  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_good  <= w_good_next;
         r_lost  <= w_lost_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_good_next  = r_good;
      w_lost_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_fsm_edge) begin
               w_state_next = ST_MEASURE;
               w_good_next  = '0;
            end
         end
         ST_MEASURE: begin
            if (w_fsm_edge) begin
               if (w_in_range) begin
                  w_good_next = r_good + 1'b1;
                  if ((r_good + 1'b1) == c_lock) begin
                     w_state_next = ST_LOCKED;
                  end
               end else begin
                  w_good_next = '0;
               end
            end else if (w_timeout) begin
               w_state_next = ST_IDLE;
               w_good_next  = '0;
            end
         end
         ST_LOCKED: begin
            if (w_fsm_edge) begin
               if (!w_in_range) begin
                  w_state_next = ST_MEASURE;
                  w_good_next  = '0;
                  w_lost_next  = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_next = ST_IDLE;
               w_good_next  = '0;
               w_lost_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_good_next  = '0;
         end
      endcase
   end

   assign mon.o_posedge = r_pos;
   assign mon.o_negedge = r_neg;
   assign mon.o_edge    = w_edge;
   assign mon.o_period  = r_period;
   assign mon.o_locked  = (r_state == ST_LOCKED);
   assign mon.o_lost    = r_lost;
endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - randomized self-checking bench for clock_monitor against an event-level model.
module tb_clock_monitor;
   localparam int D  = 50;
   localparam int T  = 2;
   localparam int LC = 4;
   localparam int M_IDLE = 0, M_MEASURE = 1, M_LOCKED = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;

   clock_monitor_if #(.p_width(16)) mon ();

   clock_monitor #(
      .p_divider(D), .p_tolerance(T), .p_lock_count(LC), .p_width(16)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .mon(mon)
   );

   always #5 clk = ~clk;

   // Model: toggle history (d1 = value applied one sample ago), pulse timestamps, lock state.
   logic d1, d2, d3, d4;
   logic cur;
   int m_t, m_last, m_state, m_good, exp_period;
   logic m_prev_pulse, exp_pos, exp_neg, exp_locked, exp_lost;
   logic [20:0] act_vec, exp_vec;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mon.i_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mon.i_in = 1'b0;
      cur = 1'b0;
      {d1, d2, d3, d4} = 4'b0;
      m_t = 1;
      m_last = 0;
      m_state = M_IDLE;
      m_good = 0;
      m_prev_pulse = 1'b0;
      exp_period = 0;
   endtask

   // One sample per falling edge: score the event of the previous sample, then drive v.
   task automatic step(input logic v);
      int iv;
      bit inr;
      @(negedge clk);
      exp_lost = 1'b0;
      iv = m_t - 1 - m_last;
      if (m_prev_pulse) begin
         exp_period = iv;
         inr = (iv >= D - T) && (iv <= D + T);
         if (m_state == M_IDLE) begin
            m_state = M_MEASURE;
            m_good = 0;
         end else if (m_state == M_MEASURE) begin
            if (inr) begin
               m_good++;
               if (m_good == LC) m_state = M_LOCKED;
            end else begin
               m_good = 0;
            end
         end else if (!inr) begin
            m_state = M_MEASURE;
            m_good = 0;
            exp_lost = 1'b1;
         end
         m_last = m_t - 1;
      end else if (m_state != M_IDLE && iv == D + T + 1) begin
         if (m_state == M_LOCKED) exp_lost = 1'b1;
         m_state = M_IDLE;
         m_good = 0;
      end
      exp_locked = (m_state == M_LOCKED);
      exp_pos = d3 && !d4;
      exp_neg = !d3 && d4;
      m_prev_pulse = exp_pos | exp_neg;
      exp_vec = {exp_pos, exp_neg, exp_pos | exp_neg, exp_locked, exp_lost, 16'(exp_period)};
      act_vec = {mon.o_posedge, mon.o_negedge, mon.o_edge, mon.o_locked, mon.o_lost, mon.o_period};
      d4 = d3; d3 = d2; d2 = d1; d1 = v;
      mon.i_in = v;
      m_t++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({mon.o_posedge, mon.o_negedge, mon.o_edge, mon.o_locked, mon.o_lost, mon.o_period} !== 21'd0) begin
            failures++;
            $display("FAIL reset_hold i=%0d got=%h want=0", i, {mon.o_posedge, mon.o_negedge, mon.o_edge,
                     mon.o_locked, mon.o_lost, mon.o_period});
         end
         mon.i_in = 1'($urandom);
      end
   endtask

   task automatic test_ideal_lock();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < D; j++) begin
            if (j == 0) cur = ~cur;
            step(cur);
            checks++;
            if (act_vec !== exp_vec) begin
               failures++;
               $display("FAIL ideal t=%0d got=%h want=%h", m_t, act_vec, exp_vec);
            end
         end
      end
      checks++;
      if (mon.o_locked !== 1'b1) begin
         failures++;
         $display("FAIL ideal_final_lock got=%b want=1", mon.o_locked);
      end
   endtask

   task automatic test_out_of_range();
      logic seen_lock = 1'b0;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 53; j++) begin
            if (j == 0) cur = ~cur;
            step(cur);
            seen_lock |= act_vec[17];
            checks++;
            if (act_vec !== exp_vec) begin
               failures++;
               $display("FAIL range53 t=%0d got=%h want=%h", m_t, act_vec, exp_vec);
            end
         end
      end
      checks++;
      if (seen_lock !== 1'b0 || mon.o_period !== 16'd53) begin
         failures++;
         $display("FAIL range53_summary locked_seen=%b period=%0d want 0/53", seen_lock, mon.o_period);
      end
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 48; j++) begin
            if (j == 0) cur = ~cur;
            step(cur);
            checks++;
            if (act_vec !== exp_vec) begin
               failures++;
               $display("FAIL range48 t=%0d got=%h want=%h", m_t, act_vec, exp_vec);
            end
         end
      end
      checks++;
      if (mon.o_locked !== 1'b1) begin
         failures++;
         $display("FAIL range48_lock got=%b want=1", mon.o_locked);
      end
   endtask

   task automatic test_stall();
      int lost_cnt = 0;
      do_reset();
      for (int i = 0; i < 7 * D + 80; i++) begin
         if (i < 7 * D && i % D == 0) cur = ~cur;
         step(cur);
         if (act_vec[16]) lost_cnt++;
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL stall t=%0d got=%h want=%h", m_t, act_vec, exp_vec);
         end
      end
      checks++;
      if (lost_cnt != 1 || mon.o_locked !== 1'b0) begin
         failures++;
         $display("FAIL stall_summary lost_pulses=%0d locked=%b want 1/0", lost_cnt, mon.o_locked);
      end
   endtask

   task automatic test_bad_edge();
      int hp[$] = '{50, 50, 50, 50, 50, 50, 50, 30, 50, 50, 50, 50, 50, 50};
      int lost_cnt = 0;
      logic seen30 = 1'b0;
      do_reset();
      foreach (hp[k]) begin
         for (int j = 0; j < hp[k]; j++) begin
            if (j == 0) cur = ~cur;
            step(cur);
            if (act_vec[16]) lost_cnt++;
            if (act_vec[15:0] == 16'd30) seen30 = 1'b1;
            checks++;
            if (act_vec !== exp_vec) begin
               failures++;
               $display("FAIL bad_edge t=%0d got=%h want=%h", m_t, act_vec, exp_vec);
            end
         end
      end
      checks++;
      if (lost_cnt != 1 || !seen30 || mon.o_locked !== 1'b1) begin
         failures++;
         $display("FAIL bad_edge_summary lost=%0d saw30=%b locked=%b want 1/1/1", lost_cnt, seen30, mon.o_locked);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 6 * D + 5; i++) begin
         if (i < 6 * D && i % D == 0) cur = ~cur;
         step(cur);
      end
      checks++;
      if (mon.o_locked !== 1'b1) begin
         failures++;
         $display("FAIL async_pre_lock got=%b want=1", mon.o_locked);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (mon.o_locked !== 1'b0 || mon.o_lost !== 1'b0 || mon.o_period !== 16'd0) begin
         failures++;
         $display("FAIL async_reset locked=%b lost=%b period=%0d want 0/0/0", mon.o_locked, mon.o_lost, mon.o_period);
      end
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(cur);
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL async_after t=%0d got=%h want=%h", m_t, act_vec, exp_vec);
         end
      end
   endtask

   task automatic test_random();
      int hp, r;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(0, 9));
         hp = (r < 7) ? int'($urandom_range(46, 54)) :
              (r < 9) ? int'($urandom_range(1, 4)) : int'($urandom_range(55, 70));
         for (int j = 0; j < hp; j++) begin
            if (j == 0) cur = ~cur;
            step(cur);
            checks++;
            if (act_vec !== exp_vec) begin
               failures++;
               $display("FAIL random t=%0d hp=%0d got=%h want=%h", m_t, hp, act_vec, exp_vec);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i < 12) cur = ~cur;
         step(cur);
         if (act_vec[18]) pulses++;
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL back_to_back t=%0d got=%h want=%h", m_t, act_vec, exp_vec);
         end
      end
      checks++;
      if (pulses != 12) begin
         failures++;
         $display("FAIL back_to_back_count got=%0d want=12", pulses);
      end
   endtask

`ifdef CLOCK_MONITOR_STOP_EN
   task automatic test_stop();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 6 * D + 5; i++) begin
         if (i < 6 * D && i % D == 0) cur = ~cur;
         step(cur);
      end
      @(negedge clk);
      mon.i_stop = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (mon.o_locked !== 1'b1 || mon.o_lost !== 1'b0) bad++;
      end
      mon.i_stop = 1'b0;
      for (int i = 0; i < 8 * D; i++) begin
         @(negedge clk);
         if (mon.o_locked !== 1'b1 || mon.o_lost !== 1'b0) bad++;
         if (i % D == 0) cur = ~cur;
         mon.i_in = cur;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL stop_hold bad_cycles=%0d want=0", bad);
      end
   endtask
`endif

   initial begin
      mon.i_in = 1'b0;
`ifdef CLOCK_MONITOR_STOP_EN
      mon.i_stop = 1'b0;
`endif
      cur = 1'b0;
      test_reset();
      test_ideal_lock();
      test_out_of_range();
      test_stall();
      test_bad_edge();
      test_async_reset();
      test_random();
      test_back_to_back();
`ifdef CLOCK_MONITOR_STOP_EN
      test_stop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
